// File: rtl/sb_pkg.sv
// Shared types and helpers for the dm_store_buffer slice.
// The entry word field is sized for AW up to 32.
package sb_pkg;
    localparam int BYTES  = 4;
    localparam int WORD_W = 30;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [31:0]       data;
        logic [BYTES-1:0]  byteen;
        logic [31:0]       pc;
    } sb_entry_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0]      old_word,
                                                input logic [31:0]      new_word,
                                                input logic [BYTES-1:0] byteen);
        logic [31:0] r;
        r = old_word;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (byteen[b]) r[8*b +: 8] = new_word[8*b +: 8];
        end
        return r;
    endfunction
endpackage

// File: rtl/sb_fwd_merge.sv
// Oldest-to-youngest scan of the valid store-buffer entries.
// Produces the byte-merged load word and a word-address hit flag.
module sb_fwd_merge
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][WORD_W-1:0] words,
    input  logic [DEPTH-1:0][31:0]       datas,
    input  logic [DEPTH-1:0][BYTES-1:0]  byteens,
    input  logic [PW-1:0]                head,
    input  logic [PW:0]                  count,
    input  logic [WORD_W-1:0]            word,
    input  logic [31:0]                  base,
    output logic [31:0]                  merged,
    output logic                         hit
);
    logic [PW-1:0] merge_idx;
    logic [PW-1:0] hit_idx;

    // Kept separate from the hit scan: base depends on hit through the port mux.
    always_comb begin
        merged    = base;
        merge_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            merge_idx = head + PW'(i);
            if ((PW+1)'(i) < count && words[merge_idx] == word)
                merged = merge_bytes(merged, datas[merge_idx], byteens[merge_idx]);
        end
    end

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit_idx = head + PW'(i);
            if ((PW+1)'(i) < count && words[hit_idx] == word)
                hit = 1'b1;
        end
    end
endmodule

// File: rtl/dm_store_buffer.sv
// Store buffer between the CPU data port and word-addressed data memory.
// Define SB_FORWARD_EN for byte-merge forwarding; otherwise matching loads stall until drained.
module dm_store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_st_valid,
    output logic          cpu_st_ready,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_byteen,
    input  logic [31:0]   cpu_inst_addr,
    input  logic          cpu_ld,
    output logic          cpu_ld_ready,
    output logic [31:0]   cpu_rdata,
    output logic [AW-1:0] m_data_addr,
    output logic [31:0]   m_data_wdata,
    output logic [3:0]    m_data_byteen,
    input  logic [31:0]   m_data_rdata,
    output logic [31:0]   m_inst_addr,
    output logic          sb_empty
);
    localparam int PW = $clog2(DEPTH);

    sb_entry_t [DEPTH-1:0]         entries;
    logic [DEPTH-1:0][WORD_W-1:0]  words;
    logic [DEPTH-1:0][31:0]        datas;
    logic [DEPTH-1:0][BYTES-1:0]   byteens;
    logic [PW-1:0]                 head;
    logic [PW-1:0]                 tail;
    logic [PW:0]                   count;
    logic [WORD_W-1:0]             ld_word;
    sb_entry_t                     head_e;
    logic [31:0]                   merged;
    logic                          hit;
    logic                          ld_block;
    logic                          enq;
    logic                          wr;
    logic                          drain;
    logic                          unused_bits;

    assign ld_word      = WORD_W'(cpu_addr[AW-1:2]);
    assign head_e       = entries[head];
    assign cpu_st_ready = count < (PW+1)'(DEPTH);
    assign sb_empty     = count == '0;
    assign enq          = cpu_st_valid && cpu_st_ready;
    assign wr           = enq && (cpu_byteen != '0);
    assign drain        = (count != '0) && (!cpu_ld || ld_block);

    always_comb begin
        words   = '0;
        datas   = '0;
        byteens = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            words[i]   = entries[i].word;
            datas[i]   = entries[i].data;
            byteens[i] = entries[i].byteen;
        end
    end

    sb_fwd_merge #(.DEPTH(DEPTH), .PW(PW)) u_fwd_merge (
        .words   (words),
        .datas   (datas),
        .byteens (byteens),
        .head    (head),
        .count   (count),
        .word    (ld_word),
        .base    (m_data_rdata),
        .merged  (merged),
        .hit     (hit)
    );

`ifdef SB_FORWARD_EN
    assign ld_block     = 1'b0;
    assign cpu_ld_ready = 1'b1;
    assign cpu_rdata    = merged;
    assign unused_bits  = ^{cpu_addr[1:0], hit};
`else
    // A matching load gives up the port so the head keeps draining until the hit clears.
    assign ld_block     = cpu_ld && hit;
    assign cpu_ld_ready = !hit;
    assign cpu_rdata    = m_data_rdata;
    assign unused_bits  = ^{cpu_addr[1:0], merged};
`endif

    always_comb begin
        m_data_addr   = '0;
        m_data_wdata  = '0;
        m_data_byteen = '0;
        m_inst_addr   = '0;
        if (cpu_ld && !ld_block) begin
            m_data_addr = {cpu_addr[AW-1:2], 2'b00};
        end else if (drain) begin
            m_data_addr   = {head_e.word[AW-3:0], 2'b00};
            m_data_wdata  = head_e.data;
            m_data_byteen = head_e.byteen;
            m_inst_addr   = head_e.pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr)    tail <= tail + PW'(1);
            if (drain) head <= head + PW'(1);
            count <= count + (PW+1)'(wr) - (PW+1)'(drain);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) entries[tail] <= '{word: ld_word, data: cpu_wdata, byteen: cpu_byteen, pc: cpu_inst_addr};
    end
endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed self-checking bench for dm_store_buffer with a behavioural data memory.
// Forwarding or stall scenarios are selected by SB_FORWARD_EN, matching the RTL build.
module tb_dm_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk;
    logic          reset;
    logic          cpu_st_valid;
    logic          cpu_st_ready;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [3:0]    cpu_byteen;
    logic [31:0]   cpu_inst_addr;
    logic          cpu_ld;
    logic          cpu_ld_ready;
    logic [31:0]   cpu_rdata;
    logic [AW-1:0] m_data_addr;
    logic [31:0]   m_data_wdata;
    logic [3:0]    m_data_byteen;
    logic [31:0]   m_data_rdata;
    logic [31:0]   m_inst_addr;
    logic          sb_empty;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:63] = '{default: 32'h0};
    logic [31:0] wlog [$];

    dm_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_st_valid  (cpu_st_valid),
        .cpu_st_ready  (cpu_st_ready),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_byteen    (cpu_byteen),
        .cpu_inst_addr (cpu_inst_addr),
        .cpu_ld        (cpu_ld),
        .cpu_ld_ready  (cpu_ld_ready),
        .cpu_rdata     (cpu_rdata),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_data_rdata  (m_data_rdata),
        .m_inst_addr   (m_inst_addr),
        .sb_empty      (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign m_data_rdata = mem[m_data_addr[7:2]];

    always @(posedge clk) begin
        if (m_data_byteen != 4'b0000) begin
            logic [31:0] w;
            w = mem[m_data_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (m_data_byteen[b]) w[8*b +: 8] = m_data_wdata[8*b +: 8];
            mem[m_data_addr[7:2]] <= w;
            wlog.push_back(m_data_addr);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        cpu_st_valid  = 1'b0;
        cpu_addr      = '0;
        cpu_wdata     = '0;
        cpu_byteen    = '0;
        cpu_inst_addr = '0;
        cpu_ld        = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic [31:0] pc);
        cpu_st_valid  = 1'b1;
        cpu_addr      = a;
        cpu_wdata     = d;
        cpu_byteen    = be;
        cpu_inst_addr = pc;
    endtask

    task automatic drain_wait;
        for (int c = 0; c < 12 && !sb_empty; c++) tick();
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b0;
        #3;
        total++; if (m_data_byteen !== 4'b0)  begin bad++; $display("FAIL rst_byteen got=%h want=0", m_data_byteen); end
        total++; if (sb_empty !== 1'b1)       begin bad++; $display("FAIL rst_empty got=%b want=1", sb_empty); end
        total++; if (cpu_st_ready !== 1'b1)   begin bad++; $display("FAIL rst_st_ready got=%b want=1", cpu_st_ready); end
        total++; if (cpu_ld_ready !== 1'b1)   begin bad++; $display("FAIL rst_ld_ready got=%b want=1", cpu_ld_ready); end
        total++; if (m_data_addr !== 32'h0)   begin bad++; $display("FAIL rst_addr got=%h want=0", m_data_addr); end
        total++; if (m_inst_addr !== 32'h0)   begin bad++; $display("FAIL rst_pc got=%h want=0", m_inst_addr); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_drain;
        int n0;
        n0 = wlog.size();
        store(32'h10, 32'h12345678, 4'hF, 32'h400);
        #1;
        total++; if (cpu_st_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", cpu_st_ready); end
        tick();
        clear_inputs();
        #1;
        total++; if (sb_empty !== 1'b0)           begin bad++; $display("FAIL single_notempty got=%b want=0", sb_empty); end
        total++; if (m_data_addr !== 32'h10)      begin bad++; $display("FAIL single_addr got=%h want=10", m_data_addr); end
        total++; if (m_data_wdata !== 32'h12345678) begin bad++; $display("FAIL single_wdata got=%h want=12345678", m_data_wdata); end
        total++; if (m_data_byteen !== 4'hF)      begin bad++; $display("FAIL single_byteen got=%h want=f", m_data_byteen); end
        total++; if (m_inst_addr !== 32'h400)     begin bad++; $display("FAIL single_pc got=%h want=400", m_inst_addr); end
        tick();
        total++; if (sb_empty !== 1'b1)           begin bad++; $display("FAIL single_empty got=%b want=1", sb_empty); end
        total++; if (m_data_byteen !== 4'h0)      begin bad++; $display("FAIL single_idle got=%h want=0", m_data_byteen); end
        total++; if (mem[4] !== 32'h12345678)     begin bad++; $display("FAIL single_mem got=%h want=12345678", mem[4]); end
        total++; if (wlog.size() !== n0 + 1)      begin bad++; $display("FAIL single_wcount got=%0d want=%0d", wlog.size(), n0 + 1); end
    endtask

    task automatic test_zero_byteen;
        store(32'h14, 32'hDEADBEEF, 4'h0, 32'h404);
        #1;
        total++; if (cpu_st_ready !== 1'b1) begin bad++; $display("FAIL zbe_ready got=%b want=1", cpu_st_ready); end
        tick();
        clear_inputs();
        #1;
        total++; if (sb_empty !== 1'b1)      begin bad++; $display("FAIL zbe_empty got=%b want=1", sb_empty); end
        total++; if (m_data_byteen !== 4'h0) begin bad++; $display("FAIL zbe_byteen got=%h want=0", m_data_byteen); end
    endtask

    task automatic test_full;
        int n0;
        int waited;
        logic acc;
        logic exp_rdy;
        n0 = wlog.size();
        cpu_ld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            store(32'h80 + 4 * i, 32'hD000_0000 + i, 4'hF, 32'h500 + 4 * i);
            #1;
            exp_rdy = (i < 4);
            total++; if (cpu_st_ready !== exp_rdy) begin bad++; $display("FAIL full_ready%0d got=%b want=%b", i, cpu_st_ready, exp_rdy); end
            total++; if (m_data_byteen !== 4'h0)   begin bad++; $display("FAIL full_nodrain%0d got=%h want=0", i, m_data_byteen); end
            if (i < 4) tick();
        end
        tick();
        total++; if (cpu_st_ready !== 1'b0) begin bad++; $display("FAIL full_hold got=%b want=0", cpu_st_ready); end
        cpu_ld = 1'b0;
        #1;
        total++; if (m_data_addr !== 32'h80)  begin bad++; $display("FAIL full_head_addr got=%h want=80", m_data_addr); end
        total++; if (cpu_st_ready !== 1'b0)   begin bad++; $display("FAIL full_ready_drain got=%b want=0", cpu_st_ready); end
        acc = 1'b0;
        waited = 0;
        for (int c = 0; c < 8 && !acc; c++) begin
            if (cpu_st_ready) acc = 1'b1;
            tick();
            waited++;
        end
        cpu_st_valid = 1'b0;
        total++; if (acc !== 1'b1 || waited !== 2) begin bad++; $display("FAIL full_accept5 got=%b/%0d want=1/2", acc, waited); end
        drain_wait();
        total++; if (sb_empty !== 1'b1)       begin bad++; $display("FAIL full_drained got=%b want=1", sb_empty); end
        total++; if (wlog.size() !== n0 + 5)  begin bad++; $display("FAIL full_wcount got=%0d want=%0d", wlog.size(), n0 + 5); end
        for (int k = 0; k < 5 && n0 + k < wlog.size(); k++) begin
            total++; if (wlog[n0 + k] !== 32'h80 + 4 * k) begin bad++; $display("FAIL full_order%0d got=%h want=%h", k, wlog[n0 + k], 32'h80 + 4 * k); end
        end
        total++; if (mem[36] !== 32'hD000_0004) begin bad++; $display("FAIL full_mem5 got=%h want=d0000004", mem[36]); end
        clear_inputs();
    endtask

`ifdef SB_FORWARD_EN
    task automatic test_forward_byte;
        store(32'h20, 32'h11223344, 4'hF, 32'h600);
        tick();
        clear_inputs();
        drain_wait();
        cpu_ld = 1'b1;
        store(32'h21, 32'h0000AB00, 4'b0010, 32'h604);
        tick();
        cpu_st_valid = 1'b0;
        cpu_addr     = 32'h20;
        #1;
        total++; if (cpu_rdata !== 32'h1122AB44) begin bad++; $display("FAIL fwd_byte got=%h want=1122ab44", cpu_rdata); end
        total++; if (cpu_ld_ready !== 1'b1)      begin bad++; $display("FAIL fwd_ready got=%b want=1", cpu_ld_ready); end
        total++; if (m_data_byteen !== 4'h0)     begin bad++; $display("FAIL fwd_nodrain got=%h want=0", m_data_byteen); end
        clear_inputs();
        drain_wait();
        total++; if (mem[8] !== 32'h1122AB44)    begin bad++; $display("FAIL fwd_mem got=%h want=1122ab44", mem[8]); end
    endtask

    task automatic test_forward_youngest;
        cpu_ld = 1'b1;
        store(32'h40, 32'hAAAAAAAA, 4'hF, 32'h700);
        tick();
        store(32'h40, 32'h000000BB, 4'b0001, 32'h704);
        tick();
        cpu_st_valid = 1'b0;
        #1;
        total++; if (cpu_rdata !== 32'hAAAAAABB) begin bad++; $display("FAIL fwd_young got=%h want=aaaaaabb", cpu_rdata); end
        clear_inputs();
        tick();
        total++; if (mem[16] !== 32'hAAAAAAAA)   begin bad++; $display("FAIL fwd_order1 got=%h want=aaaaaaaa", mem[16]); end
        tick();
        total++; if (mem[16] !== 32'hAAAAAABB)   begin bad++; $display("FAIL fwd_order2 got=%h want=aaaaaabb", mem[16]); end
    endtask
`else
    task automatic test_ld_stall;
        store(32'h20, 32'h11223344, 4'hF, 32'h600);
        tick();
        clear_inputs();
        drain_wait();
        cpu_ld = 1'b1;
        store(32'h20, 32'hCAFEF00D, 4'hF, 32'h604);
        #1;
        total++; if (cpu_ld_ready !== 1'b1)      begin bad++; $display("FAIL stall_same_ready got=%b want=1", cpu_ld_ready); end
        total++; if (cpu_rdata !== 32'h11223344) begin bad++; $display("FAIL stall_same_data got=%h want=11223344", cpu_rdata); end
        tick();
        cpu_st_valid = 1'b0;
        #1;
        total++; if (cpu_ld_ready !== 1'b0)      begin bad++; $display("FAIL stall_ready got=%b want=0", cpu_ld_ready); end
        total++; if (m_data_byteen !== 4'hF)     begin bad++; $display("FAIL stall_drain got=%h want=f", m_data_byteen); end
        total++; if (m_data_addr !== 32'h20)     begin bad++; $display("FAIL stall_addr got=%h want=20", m_data_addr); end
        tick();
        total++; if (cpu_ld_ready !== 1'b1)      begin bad++; $display("FAIL stall_release got=%b want=1", cpu_ld_ready); end
        total++; if (cpu_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL stall_data got=%h want=cafef00d", cpu_rdata); end
        total++; if (sb_empty !== 1'b1)          begin bad++; $display("FAIL stall_empty got=%b want=1", sb_empty); end
        clear_inputs();
    endtask

    task automatic test_ld_nomatch;
        cpu_ld = 1'b1;
        store(32'h24, 32'h00000055, 4'hF, 32'h608);
        tick();
        cpu_st_valid = 1'b0;
        cpu_addr     = 32'h30;
        #1;
        total++; if (cpu_ld_ready !== 1'b1)  begin bad++; $display("FAIL nomatch_ready got=%b want=1", cpu_ld_ready); end
        total++; if (m_data_byteen !== 4'h0) begin bad++; $display("FAIL nomatch_nodrain got=%h want=0", m_data_byteen); end
        total++; if (cpu_rdata !== 32'h0)    begin bad++; $display("FAIL nomatch_data got=%h want=0", cpu_rdata); end
        clear_inputs();
        drain_wait();
        total++; if (mem[9] !== 32'h55)      begin bad++; $display("FAIL nomatch_mem got=%h want=55", mem[9]); end
    endtask
`endif

    task automatic test_reset_mid_drain;
        int n0;
        n0 = wlog.size();
        cpu_ld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            store(32'hA0 + 4 * i, 32'h1 + i, 4'hF, 32'h800 + 4 * i);
            tick();
        end
        clear_inputs();
        #1;
        total++; if (m_data_byteen !== 4'hF) begin bad++; $display("FAIL rmd_pre got=%h want=f", m_data_byteen); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (m_data_byteen !== 4'h0) begin bad++; $display("FAIL rmd_byteen got=%h want=0", m_data_byteen); end
        total++; if (sb_empty !== 1'b1)      begin bad++; $display("FAIL rmd_empty got=%b want=1", sb_empty); end
        total++; if (cpu_st_ready !== 1'b1)  begin bad++; $display("FAIL rmd_ready got=%b want=1", cpu_st_ready); end
        @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (4) tick();
        total++; if (wlog.size() !== n0)     begin bad++; $display("FAIL rmd_writes got=%0d want=%0d", wlog.size(), n0); end
        total++; if (mem[40] !== 32'h0)      begin bad++; $display("FAIL rmd_mem got=%h want=0", mem[40]); end
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_single_drain();
        test_zero_byteen();
        test_full();
`ifdef SB_FORWARD_EN
        test_forward_byte();
        test_forward_youngest();
`else
        test_ld_stall();
        test_ld_nomatch();
`endif
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
